// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter.
// Runs the inhibit / request-to-send sequence and clocks one 11-bit frame out
// on device-generated clocks. It also watches for device timeouts.
// Build option: define PS2_TX_ACK_CHECK_EN to sample the device ACK bit and
// wait for line release before finishing. When it is undefined, ack_err is 0
// and the 11th falling edge ends the transfer.
module ps2_host_tx #(
    parameter int INHIBIT_CYC       = 6000,
    parameter int REQ_CYC           = 250,
    parameter int FIRST_TIMEOUT_CYC = 750000,
    parameter int BIT_TIMEOUT_CYC   = 100000,
    parameter int FILTER_LEN        = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic       timeout_err
);

    localparam int MAX_A = (INHIBIT_CYC > REQ_CYC) ? INHIBIT_CYC : REQ_CYC;
    localparam int MAX_B = (FIRST_TIMEOUT_CYC > BIT_TIMEOUT_CYC) ? FIRST_TIMEOUT_CYC : BIT_TIMEOUT_CYC;
    localparam int MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW    = $clog2(MAX_C + 1);
    localparam int FW    = $clog2(FILTER_LEN + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_REQ,
        S_SEND,
        S_ACK,
        S_RELEASE
    } state_t;

    // Index 0 is the clock line and index 1 is the data line.
    logic [1:0] pad_in;
    logic [1:0] filt;
    assign pad_in = {ps2_data, ps2_clk};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_cond
            logic          sync1_reg;
            logic          sync2_reg;
            logic          filt_reg;
            logic [FW-1:0] fcnt_reg;

            // Two-flop synchronizer, then a run-length filter.
            // The filter flips its level only after FILTER_LEN consecutive
            // samples disagree with it. Reset assumes the idle level, which
            // is high because of the pull-up.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    sync1_reg <= 1'b1;
                    sync2_reg <= 1'b1;
                    filt_reg  <= 1'b1;
                    fcnt_reg  <= '0;
                end else begin
                    sync1_reg <= pad_in[gi];
                    sync2_reg <= sync1_reg;
                    if (sync2_reg == filt_reg) begin
                        fcnt_reg <= '0;
                    end else if (fcnt_reg == FW'(FILTER_LEN - 1)) begin
                        filt_reg <= sync2_reg;
                        fcnt_reg <= '0;
                    end else begin
                        fcnt_reg <= fcnt_reg + 1'b1;
                    end
                end
            end

            assign filt[gi] = filt_reg;
        end
    endgenerate

    logic fclk;
    logic fdata;
    logic fclk_d_reg;
    logic fclk_fall;
    assign fclk      = filt[0];
    assign fdata     = filt[1];
    assign fclk_fall = fclk_d_reg & ~fclk;

    // Delayed copy of the filtered clock, used for falling-edge detection.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fclk_d_reg <= 1'b1;
        end else begin
            fclk_d_reg <= fclk;
        end
    end

    // Frame bit presented after falling edge number idx+1.
    // idx 0..7 selects the data bits, 8 selects odd parity, and 9 selects stop.
    function automatic logic frame_bit(input logic [3:0] idx, input logic [7:0] d);
        logic b;
        if (idx < 4'd8) begin
            b = d[idx[2:0]];
        end else if (idx == 4'd8) begin
            b = ~^d;
        end else begin
            b = 1'b1;
        end
        return b;
    endfunction

    state_t        state_reg;
    logic [CW-1:0] cnt_reg;
    logic [3:0]    bit_idx_reg;
    logic [7:0]    data_reg;
    logic          clk_oe_reg;
    logic          data_oe_reg;
    logic          busy_reg;
    logic          done_reg;
    logic          timeout_err_reg;
`ifdef PS2_TX_ACK_CHECK_EN
    logic          ack_err_reg;
`endif

    // Transfer sequencer. All outputs are registered here.
    // cnt_reg counts up through the inhibit and request phases. It counts
    // down as a watchdog while the device is clocking.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg       <= S_IDLE;
            cnt_reg         <= '0;
            bit_idx_reg     <= '0;
            data_reg        <= '0;
            clk_oe_reg      <= 1'b0;
            data_oe_reg     <= 1'b0;
            busy_reg        <= 1'b0;
            done_reg        <= 1'b0;
            timeout_err_reg <= 1'b0;
`ifdef PS2_TX_ACK_CHECK_EN
            ack_err_reg     <= 1'b0;
`endif
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    clk_oe_reg  <= 1'b0;
                    data_oe_reg <= 1'b0;
                    if (tx_start) begin
                        data_reg        <= tx_data;
                        timeout_err_reg <= 1'b0;
`ifdef PS2_TX_ACK_CHECK_EN
                        ack_err_reg     <= 1'b0;
`endif
                        busy_reg        <= 1'b1;
                        clk_oe_reg      <= 1'b1;
                        cnt_reg         <= '0;
                        state_reg       <= S_INHIBIT;
                    end
                end
                S_INHIBIT: begin
                    if (cnt_reg == CW'(INHIBIT_CYC - 1)) begin
                        cnt_reg     <= '0;
                        data_oe_reg <= 1'b1;
                        state_reg   <= S_REQ;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                S_REQ: begin
                    if (cnt_reg == CW'(REQ_CYC - 1)) begin
                        // Release the clock line. Data stays low as the start bit.
                        clk_oe_reg  <= 1'b0;
                        cnt_reg     <= CW'(FIRST_TIMEOUT_CYC);
                        bit_idx_reg <= '0;
                        state_reg   <= S_SEND;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                S_SEND: begin
                    // A falling edge takes priority over a watchdog expiry in the same cycle.
                    if (fclk_fall) begin
                        cnt_reg <= CW'(BIT_TIMEOUT_CYC);
                        if (bit_idx_reg == 4'd10) begin
`ifdef PS2_TX_ACK_CHECK_EN
                            state_reg <= S_ACK;
`else
                            data_oe_reg <= 1'b0;
                            done_reg    <= 1'b1;
                            busy_reg    <= 1'b0;
                            cnt_reg     <= '0;
                            state_reg   <= S_IDLE;
`endif
                        end else begin
                            data_oe_reg <= ~frame_bit(bit_idx_reg, data_reg);
                            bit_idx_reg <= bit_idx_reg + 1'b1;
                        end
                    end else if (cnt_reg <= CW'(1)) begin
                        clk_oe_reg      <= 1'b0;
                        data_oe_reg     <= 1'b0;
                        timeout_err_reg <= 1'b1;
                        done_reg        <= 1'b1;
                        busy_reg        <= 1'b0;
                        cnt_reg         <= '0;
                        state_reg       <= S_IDLE;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
`ifdef PS2_TX_ACK_CHECK_EN
                S_ACK: begin
                    // The device should hold data low around the 11th clock.
                    ack_err_reg <= fdata;
                    data_oe_reg <= 1'b0;
                    cnt_reg     <= CW'(BIT_TIMEOUT_CYC);
                    state_reg   <= S_RELEASE;
                end
                S_RELEASE: begin
                    if (fclk && fdata) begin
                        done_reg  <= 1'b1;
                        busy_reg  <= 1'b0;
                        cnt_reg   <= '0;
                        state_reg <= S_IDLE;
                    end else if (cnt_reg <= CW'(1)) begin
                        clk_oe_reg      <= 1'b0;
                        data_oe_reg     <= 1'b0;
                        timeout_err_reg <= 1'b1;
                        done_reg        <= 1'b1;
                        busy_reg        <= 1'b0;
                        cnt_reg         <= '0;
                        state_reg       <= S_IDLE;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
`endif
                default: begin
                    clk_oe_reg  <= 1'b0;
                    data_oe_reg <= 1'b0;
                    busy_reg    <= 1'b0;
                    state_reg   <= S_IDLE;
                end
            endcase
        end
    end

`ifdef PS2_TX_ACK_CHECK_EN
    assign ack_err = ack_err_reg;
`else
    // The data line is not observed when ACK checking is compiled out.
    logic unused_fdata;
    assign unused_fdata = fdata;
    assign ack_err      = 1'b0;
`endif

    assign ps2_clk_oe  = clk_oe_reg;
    assign ps2_data_oe = data_oe_reg;
    assign busy        = busy_reg;
    assign done        = done_reg;
    assign timeout_err = timeout_err_reg;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: bench for ps2_host_tx with an open-drain bus and a PS/2 device model.
// The device model clocks the frame, samples the line, and can ACK, NACK, stall or stay silent.
module tb_ps2_host_tx;

    localparam int I_CYC  = 20;
    localparam int R_CYC  = 10;
    localparam int FT_CYC = 400;
    localparam int BT_CYC = 200;
    localparam int F_LEN  = 4;
    localparam int LOW_T  = 30;
    localparam int HIGH_T = 30;

`ifdef PS2_TX_ACK_CHECK_EN
    localparam bit ACKCHK = 1'b1;
`else
    localparam bit ACKCHK = 1'b0;
`endif

    localparam int M_ACK = 0, M_NACK = 1, M_NONE = 2, M_STOP4 = 3;

    logic       clk;
    logic       rst_n;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       ps2_clk;
    logic       ps2_data;
    logic       ps2_clk_oe;
    logic       ps2_data_oe;
    logic       busy;
    logic       done;
    logic       ack_err;
    logic       timeout_err;

    logic dev_clk_lo;
    logic dev_data_lo;

    // Open-drain bus: each line is low if either side pulls it low.
    assign ps2_clk  = ~(ps2_clk_oe | dev_clk_lo);
    assign ps2_data = ~(ps2_data_oe | dev_data_lo);

    ps2_host_tx #(
        .INHIBIT_CYC      (I_CYC),
        .REQ_CYC          (R_CYC),
        .FIRST_TIMEOUT_CYC(FT_CYC),
        .BIT_TIMEOUT_CYC  (BT_CYC),
        .FILTER_LEN       (F_LEN)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe),
        .busy       (busy),
        .done       (done),
        .ack_err    (ack_err),
        .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Reference frame, as seen on the line: start, d0..d7, odd parity, stop.
    function automatic logic [10:0] model_frame(input logic [7:0] d);
        logic par;
        par = (($countones(d) % 2) == 0);
        return {1'b1, par, d, 1'b0};
    endfunction

    // Device model state.
    logic [10:0] dev_frame;
    int          dev_edges;

    task automatic device(input int mode);
        bit found;
        int n_edges;
        n_edges = (mode == M_ACK || mode == M_NACK) ? 11 : (mode == M_STOP4 ? 4 : 0);
        found = 0;
        for (int i = 0; i < 300 && !found; i++) begin
            @(negedge clk);
            if (!ps2_clk_oe && ps2_data_oe) found = 1;
        end
        if (!found) return;
        repeat (HIGH_T) @(negedge clk);
        for (int e = 1; e <= n_edges; e++) begin
            dev_frame[e-1] = ps2_data;
            if (e == 11 && mode == M_ACK) begin
                dev_data_lo = 1'b1;
                repeat (5) @(negedge clk);
            end
            dev_clk_lo = 1'b1;
            dev_edges  = e;
            repeat (LOW_T) @(negedge clk);
            dev_clk_lo  = 1'b0;
            dev_data_lo = 1'b0;
            repeat (HIGH_T) @(negedge clk);
        end
    endtask

    // Results of the watcher for one transaction. Cycle 0 is the first cycle after acceptance.
    int   w_ndone, w_tclk, w_tdata, w_nclk, w_trel, w_tdone, w_busy_after;
    logic w_ack, w_to, w_busy_at, w_oe_at, w_busy_before;

    task automatic watcher(input bit extra);
        bit   seen;
        int   post;
        logic prev_busy;
        w_ndone = 0; w_tclk = -1; w_tdata = -1; w_nclk = 0; w_trel = -1; w_tdone = -1;
        w_busy_after = 0; w_ack = 1'bx; w_to = 1'bx; w_busy_at = 1'bx; w_oe_at = 1'bx;
        w_busy_before = 1'bx;
        seen = 0; post = 0; prev_busy = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            if (ps2_clk_oe) begin
                w_nclk++;
                if (w_tclk < 0) w_tclk = c;
            end else if (w_tclk >= 0 && w_trel < 0) begin
                w_trel = c;
            end
            if (ps2_data_oe && w_tdata < 0) w_tdata = c;
            if (seen && busy) w_busy_after++;
            if (done) begin
                w_ndone++;
                if (!seen) begin
                    seen = 1; w_tdone = c; w_ack = ack_err; w_to = timeout_err;
                    w_busy_at = busy; w_oe_at = ps2_clk_oe | ps2_data_oe;
                    w_busy_before = prev_busy;
                end
            end
            prev_busy = busy;
            if (extra && c == 5) begin
                tx_data  = 8'hAA;
                tx_start = 1'b1;
            end
            if (extra && c == 6) tx_start = 1'b0;
            if (seen) begin
                post++;
                if (post > 20) break;
            end
            @(negedge clk);
        end
    endtask

    task automatic run_txn(input logic [7:0] d, input int mode, input bit extra,
                           input bit exp_ack, input bit exp_to);
        logic [10:0] mf;
        logic [10:0] mask;
        int          n_bits;
        dev_frame = '0; dev_edges = 0; dev_clk_lo = 1'b0; dev_data_lo = 1'b0;
        @(negedge clk);
        tx_data  = d;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        chk("accept_busy", busy, 1);
        chk("accept_clk_oe", ps2_clk_oe, 1);
        fork
            watcher(extra);
            device(mode);
        join
        n_bits = (mode == M_ACK || mode == M_NACK) ? 11 : (mode == M_STOP4 ? 4 : 0);
        mf     = model_frame(d);
        mask   = 11'((32'd1 << n_bits) - 1);
        $display("txn data=%02h mode=%0d done_cnt=%0d ack_err=%0d timeout_err=%0d frame=%b model=%b",
                 d, mode, w_ndone, w_ack, w_to, dev_frame & mask, mf & mask);
        chk("done_count", w_ndone, 1);
        chk("ack_err", w_ack, exp_ack);
        chk("timeout_err", w_to, exp_to);
        chk("busy_at_done", w_busy_at, 0);
        chk("busy_before_done", w_busy_before, 1);
        chk("busy_after_done", w_busy_after, 0);
        chk("clk_oe_first", w_tclk, 0);
        chk("data_oe_delay", w_tdata - w_tclk, I_CYC);
        chk("clk_oe_low_time", w_nclk, I_CYC + R_CYC);
        if (n_bits > 0) chk("frame_bits", dev_frame & mask, mf & mask);
        if (exp_to) chk("oe_released_at_timeout", w_oe_at, 0);
        if (mode == M_NONE) chk("first_timeout_latency",
                                (w_tdone - w_trel >= FT_CYC) && (w_tdone - w_trel <= FT_CYC + 1), 1);
        repeat (40) @(negedge clk);
    endtask

    typedef struct {
        logic [7:0] data;
        int         mode;
        bit         exp_ack;
        bit         exp_to;
    } vec_t;

    vec_t vecs[5];
    int   rst_done_cnt;
    bit   hit;

    initial begin
        rst_n = 1'b0; tx_start = 1'b0; tx_data = 8'h00;
        dev_clk_lo = 1'b0; dev_data_lo = 1'b0; dev_frame = '0; dev_edges = 0;

        vecs[0] = '{data: 8'hED, mode: M_ACK,   exp_ack: 1'b0,   exp_to: 1'b0};
        vecs[1] = '{data: 8'hF4, mode: M_ACK,   exp_ack: 1'b0,   exp_to: 1'b0};
        vecs[2] = '{data: 8'h3C, mode: M_NACK,  exp_ack: ACKCHK, exp_to: 1'b0};
        vecs[3] = '{data: 8'hA5, mode: M_NONE,  exp_ack: 1'b0,   exp_to: 1'b1};
        vecs[4] = '{data: 8'h11, mode: M_STOP4, exp_ack: 1'b0,   exp_to: 1'b1};

        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_clk_oe", ps2_clk_oe, 0);
        chk("reset_data_oe", ps2_data_oe, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_ack_err", ack_err, 0);
        chk("reset_timeout_err", timeout_err, 0);
        repeat (20) @(negedge clk);

        for (int v = 0; v < 5; v++) begin
            run_txn(vecs[v].data, vecs[v].mode, 1'b0, vecs[v].exp_ack, vecs[v].exp_to);
            if (v == 0) chk("frame_ED_const", dev_frame, 11'b11_1110_1101_0);
            if (v == 1) chk("parity_F4", dev_frame[9], 0);
        end

        for (int r = 0; r < 6; r++) begin
            run_txn(8'($urandom_range(0, 255)), M_ACK, 1'b0, 1'b0, 1'b0);
        end

        // Reset in the middle of SEND, while the host drives a 0 data bit.
        dev_frame = '0; dev_edges = 0;
        @(negedge clk);
        tx_data  = 8'h00;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        rst_done_cnt = 0;
        fork
            device(M_STOP4);
            begin
                hit = 0;
                for (int i = 0; i < 2000 && !hit; i++) begin
                    @(negedge clk);
                    if (dev_edges == 3) hit = 1;
                end
                chk("reset_seq_reached_edge3", hit, 1);
                repeat (10) @(negedge clk);
                chk("pre_reset_data_oe", ps2_data_oe, 1);
                rst_n = 1'b0;
                @(negedge clk);
                chk("midreset_clk_oe", ps2_clk_oe, 0);
                chk("midreset_data_oe", ps2_data_oe, 0);
                chk("midreset_busy", busy, 0);
                chk("midreset_done", done, 0);
                @(negedge clk);
                rst_n = 1'b1;
                for (int i = 0; i < 300; i++) begin
                    @(negedge clk);
                    if (done) rst_done_cnt++;
                end
            end
        join
        chk("no_done_after_reset", rst_done_cnt, 0);
        $display("txn reset-mid-send done_cnt=%0d", rst_done_cnt);
        repeat (20) @(negedge clk);

        // A start pulse during a busy transfer must be ignored.
        run_txn(8'h5A, M_ACK, 1'b1, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
